matrix_row_scrubber: RTL and testbench

Sequential scrub controller for the light-ABFT matrix-code storage. It walks every row of a protected row memory; each row holds four data bytes and three check bytes. Each row is passed through one `matrix_code_row` corrector instance, and corrected rows are written back. Correctable and uncorrectable events are counted, and the first uncorrectable address is reported. It sits between the system start/status logic and the row memory's single read/write port.

---
 rtl/matrix_code_pkg.sv | 27 ++
 rtl/matrix_code_row.sv | 30 +++
 rtl/matrix_row_scrubber.sv | 125 ++++++++++++
 tb/tb_matrix_row_scrubber.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_code_pkg.sv
// rtl/matrix_code_pkg.sv - shared types and constants for the matrix-code row scrubber
package matrix_code_pkg;

    localparam int ROW_W   = 56;
    localparam int P11_LSB = 0;
    localparam int P12_LSB = 8;
    localparam int P13_LSB = 16;
    localparam int P14_LSB = 24;
    localparam int Z11_LSB = 32;
    localparam int Z12_LSB = 40;
    localparam int Z13_LSB = 48;

    typedef enum logic [2:0] {IDLE, RD, CAP, CHK, WR, DONE} state_t;

    typedef enum logic [2:0] {CLEAN, D11, D12, D13, D14, CHK_ERR, UNCORR} row_class_t;

    // Returns {c13, c12, c11}, already in z13..z11 packing order.
    function automatic logic [23:0] calc_checks(input logic [31:0] d);
        logic [7:0] p11, p12, p13, p14;
        p11 = d[P11_LSB +: 8];
        p12 = d[P12_LSB +: 8];
        p13 = d[P13_LSB +: 8];
        p14 = d[P14_LSB +: 8];
        return {p11 ^ p13 ^ p14, p11 ^ p12 ^ p14, p11 ^ p12 ^ p13};
    endfunction

endpackage

// File: rtl/matrix_code_row.sv
// rtl/matrix_code_row.sv - single-row corrector: repairs one data byte from the three syndromes
module matrix_code_row
    import matrix_code_pkg::*;
(
    input  logic [ROW_W-1:0] row,
    output logic [31:0]      q_data
);

    logic [23:0] checks;
    logic [7:0]  s1, s2, s3;

    assign checks = calc_checks(row[31:0]);
    assign s1 = checks[7:0]   ^ row[Z11_LSB +: 8];
    assign s2 = checks[15:8]  ^ row[Z12_LSB +: 8];
    assign s3 = checks[23:16] ^ row[Z13_LSB +: 8];

    // The syndrome value equals the error pattern of the flipped data byte.
    always_comb begin
        q_data = row[31:0];
        if (s1 != 8'h00 && s1 == s2 && s2 == s3)
            q_data[P11_LSB +: 8] = row[P11_LSB +: 8] ^ s1;
        else if (s1 != 8'h00 && s1 == s2 && s3 == 8'h00)
            q_data[P12_LSB +: 8] = row[P12_LSB +: 8] ^ s1;
        else if (s1 != 8'h00 && s1 == s3 && s2 == 8'h00)
            q_data[P13_LSB +: 8] = row[P13_LSB +: 8] ^ s1;
        else if (s2 != 8'h00 && s2 == s3 && s1 == 8'h00)
            q_data[P14_LSB +: 8] = row[P14_LSB +: 8] ^ s2;
    end

endmodule

// File: rtl/matrix_row_scrubber.sv
// rtl/matrix_row_scrubber.sv - scrub controller walking all rows, correcting and counting errors
module matrix_row_scrubber
    import matrix_code_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [ROW_W-1:0]  mem_rdata,
    output logic              mem_wr_en,
    output logic [ROW_W-1:0]  mem_wdata,
    output logic [7:0]        corr_cnt,
    output logic [7:0]        uncorr_cnt,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    state_t           state, next_state;
    row_class_t       cls;
    logic [ROW_W-1:0] row_q;
    logic [23:0]      chk_recalc;
    logic [7:0]       s1, s2, s3;
    logic [31:0]      corr_data, wr_data;
    logic             need_wr, last_row;

    matrix_code_row u_row (
        .row    (row_q),
        .q_data (corr_data)
    );

    assign chk_recalc = calc_checks(row_q[31:0]);
    assign s1 = chk_recalc[7:0]   ^ row_q[Z11_LSB +: 8];
    assign s2 = chk_recalc[15:8]  ^ row_q[Z12_LSB +: 8];
    assign s3 = chk_recalc[23:16] ^ row_q[Z13_LSB +: 8];

    always_comb begin
        cls = UNCORR;
        unique case ({s1 != 8'h00, s2 != 8'h00, s3 != 8'h00})
            3'b000:                 cls = CLEAN;
            3'b111:                 if (s1 == s2 && s2 == s3) cls = D11;
            3'b110:                 if (s1 == s2) cls = D12;
            3'b101:                 if (s1 == s3) cls = D13;
            3'b011:                 if (s2 == s3) cls = D14;
            3'b100, 3'b010, 3'b001: cls = CHK_ERR;
            default:                cls = UNCORR;
        endcase
    end

    assign need_wr  = (cls != CLEAN) && (cls != UNCORR);
    assign last_row = (mem_addr == LAST_ROW);
    // Check-byte errors keep the stored data; only data-byte classes take the corrector output.
    assign wr_data  = (cls == CHK_ERR) ? row_q[31:0] : corr_data;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = RD;
            RD:      next_state = CAP;
            CAP:     next_state = CHK;
            CHK:     next_state = need_wr ? WR : (last_row ? DONE : RD);
            WR:      next_state = last_row ? DONE : RD;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            row_q      <= '0;
            corr_cnt   <= 8'h00;
            uncorr_cnt <= 8'h00;
            err_valid  <= 1'b0;
            err_addr   <= '0;
        end else begin
            mem_rd_en <= (next_state == RD);
            mem_wr_en <= (next_state == WR);
            done      <= (next_state == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr   <= '0;
                        corr_cnt   <= 8'h00;
                        uncorr_cnt <= 8'h00;
                        err_valid  <= 1'b0;
                        err_addr   <= '0;
                    end
                end
                CAP: row_q <= mem_rdata;
                CHK: begin
                    if (cls == UNCORR) begin
                        if (uncorr_cnt != 8'hFF) uncorr_cnt <= uncorr_cnt + 8'd1;
                        if (!err_valid) err_addr <= mem_addr;
                        err_valid <= 1'b1;
                    end else if (need_wr) begin
                        if (corr_cnt != 8'hFF) corr_cnt <= corr_cnt + 8'd1;
                        mem_wdata <= {calc_checks(wr_data), wr_data};
                    end
                    if (!need_wr && !last_row) mem_addr <= mem_addr + 1'b1;
                end
                WR: if (!last_row) mem_addr <= mem_addr + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_row_scrubber.sv
// tb/tb_matrix_row_scrubber.sv - directed self-checking bench for matrix_row_scrubber
module tb_matrix_row_scrubber;

    localparam logic [55:0] CLEAN_ROW = 56'h66_77_00_44_33_22_11;
    localparam logic [55:0] P12_ROW   = 56'h66_77_00_44_33_2A_11;
    localparam logic [55:0] Z12_ROW   = 56'h66_70_00_44_33_22_11;
    localparam logic [55:0] DBL_ROW   = 56'h66_77_00_44_33_20_10;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, busy, done, mem_rd_en, mem_wr_en, err_valid;
    logic [3:0]  mem_addr, err_addr;
    logic [55:0] mem_rdata, mem_wdata;
    logic [7:0]  corr_cnt, uncorr_cnt;

    logic        start_b, busy_b, done_b, rd_b, wr_b, errv_b;
    logic [7:0]  addr_b, erra_b, corr_b, uncorr_b;
    logic [55:0] rdata_b, wdata_b;

    logic [55:0] mem_a [16];
    logic [55:0] img_a [16];
    logic [55:0] mem_b [256];
    logic [55:0] img_b [256];
    logic        load_a = 1'b0;
    logic        load_b = 1'b0;

    matrix_row_scrubber #(.ADDR_W(4), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .corr_cnt(corr_cnt),
        .uncorr_cnt(uncorr_cnt), .err_valid(err_valid), .err_addr(err_addr)
    );

    matrix_row_scrubber #(.ADDR_W(8), .DEPTH(256)) dut_big (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_addr(addr_b), .mem_rd_en(rd_b), .mem_rdata(rdata_b),
        .mem_wr_en(wr_b), .mem_wdata(wdata_b), .corr_cnt(corr_b),
        .uncorr_cnt(uncorr_b), .err_valid(errv_b), .err_addr(erra_b)
    );

    always @(posedge clk) begin
        if (load_a) mem_a <= img_a;
        else if (mem_wr_en) mem_a[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem_a[mem_addr];
        if (load_b) mem_b <= img_b;
        else if (wr_b) mem_b[addr_b] <= wdata_b;
        if (rd_b) rdata_b <= mem_b[addr_b];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_img_a();
        load_a = 1'b1;
        @(posedge clk); #1;
        load_a = 1'b0;
    endtask

    task automatic fill_a(input logic [55:0] v);
        for (int i = 0; i < 16; i++) img_a[i] = v;
    endtask

    task automatic run_a(input int poke, output int cyc, output int nwr, output logic [3:0] waddr,
                         output logic [55:0] wdat, output int ndone, output int both);
        cyc = 0; nwr = 0; waddr = '0; wdat = '0; ndone = 0; both = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (busy && cyc < 2000) begin
            if (mem_wr_en) begin nwr++; waddr = mem_addr; wdat = mem_wdata; end
            if (done) ndone++;
            if (mem_rd_en && mem_wr_en) both++;
            cyc++;
            if (cyc == poke) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("scan_terminates", busy, 0);
    endtask

    task automatic run_b();
        int k;
        k = 0;
        load_b = 1'b1;
        @(posedge clk); #1;
        load_b = 1'b0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        while (!done_b && k < 3000) begin @(posedge clk); #1; k++; end
        chk("big_done_seen", done_b, 1);
        @(posedge clk); #1;
    endtask

    int          cyc, nwr, ndone, both, k;
    logic [3:0]  waddr;
    logic [55:0] wdat;

    initial begin
        rst_n = 1'b0; start = 1'b0; start_b = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_strobes", {mem_rd_en, mem_wr_en}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_counts", {corr_cnt, uncorr_cnt}, 0);
        chk("rst_err", {err_valid, err_addr}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        fill_a(CLEAN_ROW); load_img_a();
        run_a(0, cyc, nwr, waddr, wdat, ndone, both);
        chk("clean_cycles", cyc, 49);
        chk("clean_writes", nwr, 0);
        chk("clean_done_pulses", ndone, 1);
        chk("clean_counts", {corr_cnt, uncorr_cnt}, 0);
        chk("clean_err_valid", err_valid, 0);

        fill_a(CLEAN_ROW); img_a[5] = P12_ROW; load_img_a();
        run_a(0, cyc, nwr, waddr, wdat, ndone, both);
        chk("p12_cycles", cyc, 50);
        chk("p12_writes", nwr, 1);
        chk("p12_wr_addr", waddr, 5);
        chk("p12_wdata", wdat, CLEAN_ROW);
        chk("p12_corr_cnt", corr_cnt, 1);
        chk("p12_no_overlap", both, 0);
        chk("p12_mem_fixed", mem_a[5], CLEAN_ROW);

        img_a[5] = P12_ROW; load_img_a();
        run_a(0, cyc, nwr, waddr, wdat, ndone, both);
        chk("rerun_corr_cleared", corr_cnt, 1);

        fill_a(CLEAN_ROW); img_a[3] = Z12_ROW; load_img_a();
        run_a(0, cyc, nwr, waddr, wdat, ndone, both);
        chk("z12_wr_addr", waddr, 3);
        chk("z12_wdata", wdat, CLEAN_ROW);
        chk("z12_corr_cnt", corr_cnt, 1);
        chk("z12_err_valid", err_valid, 0);

        fill_a(CLEAN_ROW); img_a[7] = DBL_ROW; img_a[9] = DBL_ROW; load_img_a();
        run_a(0, cyc, nwr, waddr, wdat, ndone, both);
        chk("dbl_cycles", cyc, 49);
        chk("dbl_writes", nwr, 0);
        chk("dbl_uncorr_cnt", uncorr_cnt, 2);
        chk("dbl_corr_cnt", corr_cnt, 0);
        chk("dbl_err_valid", err_valid, 1);
        chk("dbl_err_addr", err_addr, 7);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_status", {uncorr_cnt, err_valid, err_addr}, {8'd2, 1'b1, 4'd7});

        fill_a(CLEAN_ROW); load_img_a();
        run_a(10, cyc, nwr, waddr, wdat, ndone, both);
        chk("midstart_cycles", cyc, 49);
        chk("midstart_status_cleared", {uncorr_cnt, err_valid}, 0);

        img_a[5] = P12_ROW; load_img_a();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!mem_wr_en && k < 500) begin @(posedge clk); #1; k++; end
        chk("wr_reached", mem_wr_en, 1);
        rst_n = 1'b0;
        #1;
        chk("rstwr_busy", busy, 0);
        chk("rstwr_strobes", {mem_rd_en, mem_wr_en, done}, 0);
        chk("rstwr_addr", mem_addr, 0);
        chk("rstwr_wdata", mem_wdata, 0);
        chk("rstwr_corr", corr_cnt, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstwr_idle", busy, 0);

        for (int i = 0; i < 256; i++) img_b[i] = Z12_ROW;
        run_b();
        chk("sat_corr", corr_b, 255);
        chk("sat_corr_uncorr", uncorr_b, 0);
        for (int i = 0; i < 256; i++) img_b[i] = DBL_ROW;
        run_b();
        chk("sat_uncorr", uncorr_b, 255);
        chk("sat_corr_cleared", corr_b, 0);
        chk("sat_err", {errv_b, erra_b}, {1'b1, 8'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
